// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types, defaults and helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int DEF_BITS   = 12;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_BURST  = 4;
    localparam int DEF_NREQ   = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/consumer/FIFO-side signals of the write arbiter; slave is the arbiter's view.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int BITS   = DEF_BITS,
    parameter int ADDR_W = DEF_ADDR_W
) ();
    localparam int OW = (NREQ > 1) ? clog2(NREQ) : 1;

    logic [NREQ-1:0]      req;
    logic [NREQ*BITS-1:0] data;
    logic [NREQ-1:0]      gnt;
    logic                 rd;
    logic                 fifo_ready;
    logic                 fifo_write;
    logic [BITS-1:0]      fifo_data;
    logic                 fifo_read;
    logic [ADDR_W-1:0]    level;
    logic                 full;
    logic                 busy;
    logic [OW-1:0]        owner;

    modport slave (
        input  req, data, rd, fifo_ready,
        output gnt, fifo_write, fifo_data, fifo_read, level, full, busy, owner
    );

    modport master (
        output req, data, rd, fifo_ready,
        input  gnt, fifo_write, fifo_data, fifo_read, level, full, busy, owner
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin priority encoder: first requester at or after last+1 (mod NREQ).
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int OW   = (NREQ > 1) ? clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [OW-1:0]   last,
    output logic            valid,
    output logic [OW-1:0]   idx
);
    logic [2*NREQ-2:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [OW:0]       start;
    logic [OW:0]       sum;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        start = {1'b0, last} + 1'b1;
        if (start >= (OW+1)'(NREQ)) start = '0;
        dbl   = {req[NREQ-2:0], req};
        rot   = dbl[start +: NREQ];
        valid = |req;
        idx   = '0;
        sum   = '0;
        // Scan downwards so the lowest rotated position, i.e. closest after last, wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = start + (OW+1)'(i);
                idx = (sum >= (OW+1)'(NREQ)) ? OW'(sum - (OW+1)'(NREQ)) : OW'(sum);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for a shared FIFO write port with internal occupancy tracking.
// Optional FIFO_WR_ARB_PRIO_EN: requester 0 is high priority and preempts other bursts.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int BITS   = DEF_BITS,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREQ   = DEF_NREQ,
    parameter int BURST  = DEF_BURST
) (
    input logic clk,
    input logic rst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int OW  = (NREQ > 1) ? clog2(NREQ) : 1;
    localparam int CAP = (1 << ADDR_W) - 1;
    localparam int BW  = clog2(BURST + 1);

    arb_state_t        state;
    logic [OW-1:0]     owner_q;
    logic [OW-1:0]     last_q;
    logic [BW-1:0]     beats;
    logic [ADDR_W-1:0] level_q;
    logic              full_q;

    logic              pick_valid;
    logic [OW-1:0]     pick_idx;
    logic [OW-1:0]     next_owner;
    logic              beat;
    logic              pop;
    logic              preempt;
    logic              burst_done;
    logic [ADDR_W-1:0] level_nxt;
    logic [BITS-1:0]   words [NREQ];

    rr_pick #(.NREQ(NREQ), .OW(OW)) u_pick (
        .req   (bus.req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef FIFO_WR_ARB_PRIO_EN
    logic req0_q;
`endif

    always_comb begin
        for (int i = 0; i < NREQ; i++) words[i] = bus.data[i*BITS +: BITS];
        // Eligibility looks at the level before any same-cycle pop, like the FIFO itself.
        beat      = (state == XFER) && bus.req[owner_q] && (level_q != ADDR_W'(CAP));
        pop       = bus.rd && bus.fifo_ready && (level_q != '0);
        level_nxt = level_q + ADDR_W'(beat) - ADDR_W'(pop);
`ifdef FIFO_WR_ARB_PRIO_EN
        next_owner = bus.req[0] ? '0 : pick_idx;
        preempt    = (owner_q != '0) && bus.req[0] && !req0_q;
`else
        next_owner = pick_idx;
        preempt    = 1'b0;
`endif
        burst_done = !bus.req[owner_q] || (beat && (beats + 1'b1 == BW'(BURST))) || preempt;
    end

    assign bus.gnt        = beat ? (NREQ'(1) << owner_q) : '0;
    assign bus.fifo_write = beat;
    assign bus.fifo_data  = beat ? words[owner_q] : '0;
    assign bus.fifo_read  = bus.rd;
    assign bus.level      = level_q;
    assign bus.full       = full_q;
    assign bus.busy       = (state == XFER);
    assign bus.owner      = owner_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(NREQ - 1);
            beats   <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
`ifdef FIFO_WR_ARB_PRIO_EN
            req0_q  <= 1'b0;
`endif
        end else begin
            level_q <= level_nxt;
            full_q  <= (level_nxt == ADDR_W'(CAP));
`ifdef FIFO_WR_ARB_PRIO_EN
            req0_q  <= bus.req[0];
`endif
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner_q <= next_owner;
                        beats   <= '0;
                        state   <= XFER;
                    end
                end
                XFER: begin
                    if (beat) beats <= beats + 1'b1;
                    if (burst_done) begin
                        state <= IDLE;
`ifdef FIFO_WR_ARB_PRIO_EN
                        if (owner_q != '0) last_q <= owner_q;
`else
                        last_q <= owner_q;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner sequences, random vs. model.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int NREQ   = 4;
    localparam int BITS   = 12;
    localparam int ADDR_W = 3;
    localparam int BURST  = 4;
    localparam int CAP    = (1 << ADDR_W) - 1;
`ifdef FIFO_WR_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .BITS(BITS), .ADDR_W(ADDR_W)) bus ();

    fifo_wr_arbiter #(.BITS(BITS), .ADDR_W(ADDR_W), .NREQ(NREQ), .BURST(BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [BITS-1:0] word_of(input logic [NREQ*BITS-1:0] d, input int i);
        return d[i*BITS +: BITS];
    endfunction

    // Behavioural model: arbitration as a search loop, occupancy as a plain integer.
    bit m_busy;
    int m_owner, m_last, m_cnt, m_lvl;
    bit m_r0_prev;

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_cnt = 0; m_lvl = 0; m_r0_prev = 0;
    endtask

    function automatic bit model_beat();
        return m_busy && bus.req[m_owner] && (m_lvl < CAP);
    endfunction

    task automatic model_check(input string tag);
        bit b;
        b = model_beat();
        check({tag, ".gnt"},   32'(bus.gnt),        b ? 32'(1 << m_owner) : 32'd0);
        check({tag, ".write"}, 32'(bus.fifo_write), 32'(b));
        check({tag, ".data"},  32'(bus.fifo_data),  b ? 32'(word_of(bus.data, m_owner)) : 32'd0);
        check({tag, ".level"}, 32'(bus.level),      32'(m_lvl));
        check({tag, ".full"},  32'(bus.full),       32'(m_lvl == CAP));
        check({tag, ".busy"},  32'(bus.busy),       32'(m_busy));
        check({tag, ".owner"}, 32'(bus.owner),      32'(m_owner));
        check({tag, ".read"},  32'(bus.fifo_read),  32'(bus.rd));
    endtask

    task automatic model_advance();
        bit b, p;
        int w;
        b = model_beat();
        p = bus.rd && bus.fifo_ready && (m_lvl > 0);
        if (!m_busy) begin
            if (|bus.req) begin
                w = 0;
                if (PRIO && bus.req[0]) w = 0;
                else begin
                    for (int k = 1; k <= NREQ; k++) begin
                        if (bus.req[(m_last + k) % NREQ]) begin
                            w = (m_last + k) % NREQ;
                            break;
                        end
                    end
                end
                m_owner = w; m_cnt = 0; m_busy = 1;
            end
        end else begin
            if (b) m_cnt++;
            if (!bus.req[m_owner] || (b && m_cnt == BURST) ||
                (PRIO && m_owner != 0 && bus.req[0] && !m_r0_prev)) begin
                m_busy = 0;
                if (!(PRIO && m_owner == 0)) m_last = m_owner;
            end
        end
        m_lvl = m_lvl + int'(b) - int'(p);
        m_r0_prev = bus.req[0];
    endtask

    task automatic cycle_model(input string tag);
        #2;
        model_check(tag);
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0; bus.rd = 1'b0; bus.fifo_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [NREQ-1:0] req;
        logic            rd;
        logic            rdy;
        logic [NREQ-1:0] gnt;
        int              level;
        logic            full;
        logic            busy;
        int              owner;
    } vec_t;

    vec_t tbl [17];
    logic [BITS-1:0] fixed_w [NREQ];
    int  owners [8];
    int  n_bursts;
    bit  prev_busy;

    initial begin
        fixed_w = '{12'hA00, 12'hB11, 12'hC22, 12'hD33};
        // Single requester 2 (6 words), then requester 0 into full stall and read-at-full.
        tbl[0]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 0, 1'b0, 1'b0, 0};
        tbl[1]  = '{4'b0100, 1'b0, 1'b0, 4'b0100, 0, 1'b0, 1'b1, 2};
        tbl[2]  = '{4'b0100, 1'b0, 1'b0, 4'b0100, 1, 1'b0, 1'b1, 2};
        tbl[3]  = '{4'b0100, 1'b0, 1'b0, 4'b0100, 2, 1'b0, 1'b1, 2};
        tbl[4]  = '{4'b0100, 1'b0, 1'b0, 4'b0100, 3, 1'b0, 1'b1, 2};
        tbl[5]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 4, 1'b0, 1'b0, 2};
        tbl[6]  = '{4'b0100, 1'b0, 1'b0, 4'b0100, 4, 1'b0, 1'b1, 2};
        tbl[7]  = '{4'b0100, 1'b0, 1'b0, 4'b0100, 5, 1'b0, 1'b1, 2};
        tbl[8]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 6, 1'b0, 1'b1, 2};
        tbl[9]  = '{4'b0001, 1'b0, 1'b0, 4'b0000, 6, 1'b0, 1'b0, 2};
        tbl[10] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 6, 1'b0, 1'b1, 0};
        tbl[11] = '{4'b0001, 1'b0, 1'b0, 4'b0000, 7, 1'b1, 1'b1, 0};
        tbl[12] = '{4'b0001, 1'b1, 1'b1, 4'b0000, 7, 1'b1, 1'b1, 0};
        tbl[13] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 6, 1'b0, 1'b1, 0};
        tbl[14] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 7, 1'b1, 1'b1, 0};
        tbl[15] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 7, 1'b1, 1'b0, 0};
        tbl[16] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 6, 1'b0, 1'b0, 0};

        for (int i = 0; i < NREQ; i++) bus.data[i*BITS +: BITS] = fixed_w[i];
        do_reset();

        // Table-driven phase.
        for (int i = 0; i < 17; i++) begin
            bus.req = tbl[i].req; bus.rd = tbl[i].rd; bus.fifo_ready = tbl[i].rdy;
            #2;
            check($sformatf("tbl%0d.gnt", i),   32'(bus.gnt),        32'(tbl[i].gnt));
            check($sformatf("tbl%0d.write", i), 32'(bus.fifo_write), 32'(|tbl[i].gnt));
            check($sformatf("tbl%0d.data", i),  32'(bus.fifo_data),
                  (|tbl[i].gnt) ? 32'(fixed_w[tbl[i].owner]) : 32'd0);
            check($sformatf("tbl%0d.level", i), 32'(bus.level),      32'(tbl[i].level));
            check($sformatf("tbl%0d.full", i),  32'(bus.full),       32'(tbl[i].full));
            check($sformatf("tbl%0d.busy", i),  32'(bus.busy),       32'(tbl[i].busy));
            check($sformatf("tbl%0d.owner", i), 32'(bus.owner),      32'(tbl[i].owner));
            check($sformatf("tbl%0d.read", i),  32'(bus.fifo_read),  32'(tbl[i].rd));
            @(posedge clk);
            #1;
        end

        // Empty reads: strobe passes through, level does not underflow.
        do_reset();
        bus.rd = 1'b1; bus.fifo_ready = 1'b0;
        #2;
        check("empty.read", 32'(bus.fifo_read), 32'd1);
        check("empty.level0", 32'(bus.level), 32'd0);
        @(posedge clk);
        #1;
        check("empty.level1", 32'(bus.level), 32'd0);
        bus.rd = 1'b0;

        // Reset mid-burst of requester 1, asserted during beat 2.
        do_reset();
        bus.req = 4'b0110;
        cycle_model("rstmid");
        cycle_model("rstmid");
        #1;
        check("rstmid.pre_gnt", 32'(bus.gnt), 32'b0010);
        rst = 1'b1;
        #1;
        check("rstmid.gnt",   32'(bus.gnt),        32'd0);
        check("rstmid.write", 32'(bus.fifo_write), 32'd0);
        check("rstmid.data",  32'(bus.fifo_data),  32'd0);
        check("rstmid.level", 32'(bus.level),      32'd0);
        check("rstmid.busy",  32'(bus.busy),       32'd0);
        check("rstmid.owner", 32'(bus.owner),      32'd0);
        check("rstmid.full",  32'(bus.full),       32'd0);
        #1;
        rst = 1'b0;
        model_reset();
        bus.req = 4'b1111;
        @(posedge clk);
        #1;
        model_advance();
        check("rstmid.first_owner", 32'(bus.owner), 32'd0);
        check("rstmid.first_busy",  32'(bus.busy),  32'd1);

        // Contention: all four requesting, reads keep the FIFO from filling.
        do_reset();
        bus.req = 4'b1111;
        n_bursts = 0;
        prev_busy = 1'b0;
        for (int c = 0; c < 26; c++) begin
            bus.rd = 1'b1;
            bus.fifo_ready = (m_lvl != 0);
            #2;
            if (bus.busy && !prev_busy && n_bursts < 8) begin
                owners[n_bursts] = int'(bus.owner);
                n_bursts++;
            end
            prev_busy = bus.busy;
            #0;
            model_check("cont");
            model_advance();
            @(posedge clk);
            #1;
        end
        check("cont.bursts", 32'(n_bursts), 32'd5);
        for (int i = 0; i < 5; i++) check($sformatf("cont.order%0d", i), 32'(owners[i]), 32'(i % NREQ));
        bus.rd = 1'b0; bus.fifo_ready = 1'b0;

`ifdef FIFO_WR_ARB_PRIO_EN
        // Requester 0 rising during a burst of requester 3 preempts after that cycle's beat.
        do_reset();
        bus.req = 4'b1000;
        cycle_model("prio");
        cycle_model("prio");
        bus.req = 4'b1001;
        #2;
        check("prio.last_beat", 32'(bus.gnt), 32'b1000);
        cycle_model("prio");
        #2;
        check("prio.bubble", 32'(bus.busy), 32'd0);
        cycle_model("prio");
        #2;
        check("prio.owner0", 32'(bus.owner), 32'd0);
        check("prio.gnt0",   32'(bus.gnt),   32'b0001);
        cycle_model("prio");
`endif

        // Randomised run against the model, mostly-held requests to exercise bursts and full stalls.
        do_reset();
        bus.req = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++)
                if ($urandom_range(0, 3) == 0) bus.req[i] = ~bus.req[i];
            bus.data = {$urandom, $urandom};
            bus.rd = ($urandom_range(0, 2) == 0);
            bus.fifo_ready = (m_lvl != 0) && ($urandom_range(0, 3) != 0);
            cycle_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter and flow controller that shares one single-clock SRAM FIFO (depth 2^ADDR_W, usable capacity 2^ADDR_W−1 words) among NREQ producers. It grants the FIFO write port in round-robin bursts and tracks occupancy itself, so no grant ever hits the FIFO's overflow condition. It also passes the consumer's read strobe through to the FIFO. It sits between the producer blocks and the FIFO instance; the FIFO's read data path is untouched.

## Interface
- BITS, 12, FIFO word width
- ADDR_W, 3, FIFO address width; DEPTH = 2^ADDR_W, capacity CAP = DEPTH−1
- NREQ, 4, number of producers (2..8)
- BURST, 4, max words per grant (1..16)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-producer write request, held while the producer has a word
- data  in  NREQ*BITS  producer words, requester i at [i*BITS +: BITS]
- gnt  out  NREQ  one-hot, combinational; word of the owner accepted this cycle
- rd  in  1  consumer read strobe
- fifo_ready  in  1  FIFO "has data" flag
- fifo_write  out  1  FIFO write strobe (== |gnt)
- fifo_data  out  BITS  data[owner], valid when fifo_write
- fifo_read  out  1  == rd (pass-through)
- level  out  ADDR_W  current FIFO occupancy, 0..CAP
- full  out  1  level == CAP
- busy  out  1  FSM in XFER
- owner  out  clog2(NREQ)  current/last grant holder

## Operation
- FSM states: IDLE, XFER.
- IDLE: when |req, the round-robin pick takes the first requester at or after last+1 (mod NREQ). The pick is registered into owner, beats is cleared, and the FSM goes to XFER. Otherwise it stays in IDLE.
- XFER: a beat happens when req[owner] && level < CAP. On a beat: gnt[owner]=1, fifo_write=1, fifo_data=data[owner], beats+1.
- Leave XFER for IDLE on the edge after either:
  - req[owner]=0, or
  - a beat that makes beats == BURST.
- On leaving XFER, last <= owner.
- Full stall: with level == CAP and req held, the FSM stays in XFER, gnt=0, and the burst is not abandoned.
- Producer handshake: hold req and data stable; a word is consumed on each cycle its gnt bit is high; update data or drop req in the same cycle.
- Pop definition: pop = rd && fifo_ready. The FIFO ignores reads when empty, so pops are counted the same way.
- level_next = level + beat − pop.
- Beat eligibility uses the current level only, not level minus a same-cycle pop. This matches the FIFO, which compares pointers before the pop. So at level == CAP, a simultaneous rd gives no beat and level becomes CAP−1.
- Invariant: level never exceeds CAP and never underflows.

## Timing
- Reset values: gnt=0, fifo_write=0, fifo_data=0, level=0, full=0, busy=0, owner=0, last=NREQ−1 (requester 0 wins first), state IDLE.
- Reset mid-burst: everything returns to reset values immediately (asynchronous); the partial burst is lost at the arbiter; producers re-request.
- Latency: req rising in cycle n (in IDLE) gives the first gnt in cycle n+1.
- Back-to-back bursts have one IDLE bubble cycle between them.
- Max throughput: BURST words per BURST+1 cycles with contention; a single persistent requester is regranted after each bubble.
- level, full, busy, owner are registered. gnt, fifo_write, fifo_data are combinational from state, owner, level, req and data.
- fifo_read is combinational from rd; no added latency.

## Configuration
- FIFO_WR_ARB_PRIO_EN defined: requester 0 is high priority.
  - In IDLE, req[0] wins regardless of the round-robin pointer.
  - In XFER with owner≠0, a rising req[0] ends the current burst after the current cycle (that cycle's beat still happens).
  - last is not updated on a grant to requester 0.
- Undefined: pure round-robin, no preemption.

## Structure
- Package fifo_arb_pkg holds:
  - the state type (IDLE=1'b0, XFER=1'b1);
  - clog2 helper;
  - default widths (BITS, ADDR_W, BURST).
- Sub-module rr_pick: combinational NREQ-wide round-robin priority encoder. Inputs are req and last; outputs are a valid flag and the winner index.
- Top module holds the FSM, beat counter, level counter and output muxing.

## Test plan
- Single requester: req[2] held with 6 words, BURST=4 → beats in cycles 1–4, bubble, beats in 6–7; level reaches 6 and CAP=7 is not exceeded.
- Contention: req[0..3] all held → grant order 0,1,2,3,0, each with a 4-word burst, one idle cycle between bursts; owner follows that sequence.
- Full stall: with no reads, fill to level 7 → gnt=0 and busy=1. One pop cycle → level 6 → next cycle beat resumes, level back to 7.
- Simultaneous at full: level 7, rd=1 with req held → no beat that cycle, level 6; beat the following cycle.
- Empty reads: rd=1 with fifo_ready=0 and level 0 → level stays 0 and fifo_read=1 passes through.
- Reset mid-burst: assert rst during beat 2 → all outputs 0 in the same cycle; after release, requester 0 wins first. Repeat with FIFO_WR_ARB_PRIO_EN: req[0] rising during a burst by requester 3 preempts after one beat.
